// File: rtl/dmem_mmio.sv
// Data RAM plus memory-mapped TX byte FIFO, status register and free-running timer.
// Loads are combinational; every store lands on the rising clock edge.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram  [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   timer;

    logic          is_ram;
    logic          is_tx;
    logic          is_status;
    logic          is_timer;
    logic [AW-1:0] idx;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          pop;
    logic          push;
    logic          ovf_evt;
    logic [31:0]   status;
    logic          unused_addr;

    // Byte offset within a word never affects decode or data.
    assign unused_addr = ^ALUResult[1:0];

    assign is_ram    = (ALUResult[31:8] == 24'h0);
    assign is_tx     = (ALUResult[31:2] == 30'h40);
    assign is_status = (ALUResult[31:2] == 30'h41);
    assign is_timer  = (ALUResult[31:2] == 30'h42);
    assign idx       = ALUResult[AW+1:2];

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = fifo[rptr];

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign pop      = tx_valid && tx_ready;
    assign push_req = MemWrite && is_tx;
    assign push     = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;

    always_comb begin
        status      = '0;
        status[0]   = empty;
        status[1]   = full;
        status[2]   = overflow;
        status[5:3] = 3'(count);
    end

    always_comb begin
        ReadData = '0;
        unique case (1'b1)
            is_ram:    ReadData = ram[idx];
            is_status: ReadData = status;
            is_timer:  ReadData = timer;
            default:   ReadData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) begin
            ram[idx] <= WriteData;
        end
        if (!reset && push) begin
            fifo[wptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            timer    <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (MemWrite && is_status) begin
                overflow <= 1'b0;
            end
            if (MemWrite && is_timer) begin
                timer <= WriteData;
            end else begin
                timer <= timer + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, TX FIFO, STATUS, TIMER, reset and unmapped space.
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int vectors = 0;
    int miscompares = 0;

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ALUResult = a;
        #1;
        chk(tag, ReadData, exp);
    endtask

    initial begin
        logic [7:0] exp_q[4];
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        tx_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state and first post-reset timer values
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        rd("rst_timer0", 32'h108, 32'h0);
        step();
        rd("rst_timer1", 32'h108, 32'h1);
        rd("rst_status", 32'h104, 32'h01);

        // RAM
        st(32'h000, 32'h55AA55AA);
        st(32'h008, 32'hCAFEF00D);
        MemWrite  = 1'b1;
        ALUResult = 32'h008;
        WriteData = 32'h0BADF00D;
        #1;
        chk("ram_same_cycle_old", ReadData, 32'hCAFEF00D);
        step();
        MemWrite = 1'b0;
        rd("ram_new_08", 32'h008, 32'h0BADF00D);
        st(32'h004, 32'hDEADBEEF);
        rd("ram_ld_04", 32'h004, 32'hDEADBEEF);
        rd("ram_ld_07", 32'h007, 32'hDEADBEEF);
        rd("ram_ld_08", 32'h008, 32'h0BADF00D);
        rd("ram_ld_00", 32'h000, 32'h55AA55AA);
        rd("txdata_rd", 32'h100, 32'h0);

        // FIFO fill with overflow, no bypass on first push
        tx_ready  = 1'b0;
        MemWrite  = 1'b1;
        ALUResult = 32'h100;
        WriteData = 32'h11;
        #1;
        chk("no_bypass", {31'b0, tx_valid}, 32'd0);
        step();
        MemWrite = 1'b0;
        chk("valid_after_push", {31'b0, tx_valid}, 32'd1);
        chk("head_11", {24'b0, tx_data}, 32'h11);
        st(32'h100, 32'h22);
        st(32'h100, 32'h33);
        st(32'h100, 32'h44);
        st(32'h100, 32'h55);
        rd("status_full_ovf", 32'h104, 32'h26);
        tx_ready   = 1'b1;
        exp_q[0]   = 8'h11;
        exp_q[1]   = 8'h22;
        exp_q[2]   = 8'h33;
        exp_q[3]   = 8'h44;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", {31'b0, tx_valid}, 32'd1);
            chk("drain_data", {24'b0, tx_data}, {24'b0, exp_q[i]});
            step();
        end
        chk("drained_valid", {31'b0, tx_valid}, 32'd0);
        rd("status_empty_ovf", 32'h104, 32'h05);
        st(32'h104, 32'h0);
        rd("status_ovf_clr", 32'h104, 32'h01);

        // Full FIFO with simultaneous pop and push
        tx_ready = 1'b0;
        st(32'h100, 32'hA1);
        st(32'h100, 32'hA2);
        st(32'h100, 32'hA3);
        st(32'h100, 32'hA4);
        rd("status_full", 32'h104, 32'h22);
        chk("full_head", {24'b0, tx_data}, 32'hA1);
        tx_ready = 1'b1;
        st(32'h100, 32'h99);
        rd("status_full_pop", 32'h104, 32'h22);
        exp_q[0] = 8'hA2;
        exp_q[1] = 8'hA3;
        exp_q[2] = 8'hA4;
        exp_q[3] = 8'h99;
        for (int i = 0; i < 4; i++) begin
            chk("fp_data", {24'b0, tx_data}, {24'b0, exp_q[i]});
            step();
        end
        chk("fp_empty", {31'b0, tx_valid}, 32'd0);

        // Mid-count simultaneous push and pop
        tx_ready = 1'b0;
        st(32'h100, 32'hB1);
        st(32'h100, 32'hB2);
        tx_ready = 1'b1;
        st(32'h100, 32'hB3);
        rd("mid_count2", 32'h104, 32'h10);
        chk("mid_head_b2", {24'b0, tx_data}, 32'hB2);
        step();
        chk("mid_head_b3", {24'b0, tx_data}, 32'hB3);
        step();
        chk("mid_empty", {31'b0, tx_valid}, 32'd0);

        // Timer load and wrap
        st(32'h108, 32'hFFFFFFFE);
        rd("timer_fe", 32'h108, 32'hFFFFFFFE);
        step();
        rd("timer_ff", 32'h108, 32'hFFFFFFFF);
        step();
        rd("timer_wrap", 32'h108, 32'h0);

        // Reset mid-operation with entries queued
        tx_ready = 1'b0;
        st(32'h108, 32'h4E);
        st(32'h100, 32'hC1);
        st(32'h100, 32'hC2);
        rd("pre_rst_timer", 32'h108, 32'h50);
        rd("pre_rst_status", 32'h104, 32'h10);
        reset     = 1'b1;
        tx_ready  = 1'b1;
        MemWrite  = 1'b1;
        ALUResult = 32'h108;
        WriteData = 32'h1234;
        step();
        reset    = 1'b0;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        chk("post_rst_valid", {31'b0, tx_valid}, 32'd0);
        rd("post_rst_timer0", 32'h108, 32'h0);
        step();
        rd("post_rst_timer1", 32'h108, 32'h1);
        rd("post_rst_status", 32'h104, 32'h01);
        rd("ram_kept", 32'h004, 32'hDEADBEEF);

        // Unmapped store and load
        st(32'h108, 32'h1000);
        st(32'h200, 32'h12345678);
        rd("unmapped_rd", 32'h200, 32'h0);
        rd("unmapped_timer", 32'h108, 32'h1001);
        rd("unmapped_ram0", 32'h000, 32'h55AA55AA);
        rd("unmapped_status", 32'h104, 32'h01);
        chk("unmapped_valid", {31'b0, tx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter: RAM_WORDS, default 64, number of 32-bit data RAM words (power of two, max 64).
REQ-002 Parameter: FIFO_DEPTH, default 4, TX FIFO entries (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemWrite  input  1  store strobe from the core.
REQ-006 ALUResult  input  32  byte address from the core; bits [1:0] ignored.
REQ-007 WriteData  input  32  store data from the core.
REQ-008 ReadData  output  32  load data to the core, combinational from address and current state.
REQ-009 tx_data  output  8  byte at FIFO head.
REQ-010 tx_valid  output  1  high when the FIFO is not empty.
REQ-011 tx_ready  input  1  downstream consumer accepts tx_data.

Function
REQ-012 The block SHALL decode this address map: 0x000-0x0FF RAM (upper bits [31:8] zero); 0x100 TXDATA; 0x104 STATUS; 0x108 TIMER; all other addresses unmapped.
REQ-013 The RAM SHALL be indexed by ALUResult[7:2] and SHALL have a combinational read with zero-cycle latency.
REQ-014 A RAM write SHALL take effect on the rising edge when MemWrite=1, and a same-cycle read SHALL return the old word.
REQ-015 A store to TXDATA SHALL push WriteData[7:0] into the FIFO on the same edge.
REQ-016 A TXDATA push while full SHALL be dropped and SHALL set the sticky overflow flag, unless a pop occurs on the same edge; in that case the push SHALL be accepted and overflow SHALL NOT be set.
REQ-017 A pop SHALL occur on an edge where tx_valid=1 and tx_ready=1; tx_data SHALL then advance to the next entry.
REQ-018 A simultaneous push and pop with count between 1 and FIFO_DEPTH-1 SHALL leave count unchanged and preserve FIFO order.
REQ-019 A push to an empty FIFO SHALL make tx_valid=1 on the next cycle; there SHALL be no same-cycle bypass.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL range from 0 to FIFO_DEPTH.
REQ-021 A STATUS read SHALL return: bit0 empty, bit1 full, bit2 overflow, bits[5:3] count, and all other bits 0.
REQ-022 Any store to STATUS SHALL clear overflow; if an overflow event occurs on the same edge, overflow SHALL remain set.
REQ-023 TIMER SHALL be a 32-bit counter that increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
REQ-024 A store to TIMER SHALL load WriteData, with no increment on that edge.
REQ-025 A TIMER read SHALL return the current counter value.
REQ-026 A TXDATA read SHALL return 0.
REQ-027 An unmapped read SHALL return 0, and an unmapped store SHALL have no effect.
REQ-028 Only one target SHALL be written per edge, selected by the address decode.

Reset
REQ-029 While reset=1 at an edge, the block SHALL set: FIFO empty (count=0, pointers=0), overflow=0, TIMER=0, tx_valid=0.
REQ-030 Reset SHALL take priority over a simultaneous MemWrite or pop.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 ReadData SHALL reflect post-reset state from the cycle after reset deasserts.

Verification
REQ-034 RAM test: store 0xDEADBEEF to 0x04, then load 0x04 and 0x07 -> both return 0xDEADBEEF; load 0x08 returns its prior contents.
REQ-035 FIFO fill test: with tx_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 -> STATUS=0x26 (count 4, full, overflow); then set tx_ready=1 -> tx_data sequence is 0x11, 0x22, 0x33, 0x44, then tx_valid=0 and STATUS=0x05.
REQ-036 Full with simultaneous pop: FIFO full, tx_ready=1, push 0x99 -> overflow stays 0, count stays 4, and 0x99 emerges after the three remaining entries.
REQ-037 TIMER test: store 0xFFFFFFFE to 0x108 -> reads 0xFFFFFFFE next cycle, 0xFFFFFFFF the following cycle, then 0x00000000.
REQ-038 Reset test: assert reset for 1 cycle with 2 entries queued and TIMER=0x50 -> tx_valid=0, STATUS=0x01, and TIMER reads 0 then 1 after deassert.
REQ-039 Unmapped test: store 0x12345678 to 0x200 -> load 0x200 returns 0, and RAM, FIFO and TIMER are unchanged apart from the normal TIMER increment.
